// File: rtl/prio_encoder_rr_pkg.sv
// Shared constants and helpers for the registered priority encoder family.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width that stays at least 1 bit even for degenerate sizes.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle between request sources and the encoder.
interface prio_encoder_rr_if
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_safe(N)
);
  logic [N-1:0] d;
  logic         en;
  logic         ready;
  logic [W-1:0] y;
  logic         valid;
  logic         multi;

  modport master (output d, en, ready, input y, valid, multi);
  modport slave  (input d, en, ready, output y, valid, multi);
endinterface

// File: rtl/prio_encoder_rr_search.sv
// Combinational rotating highest-index search. With ptr = N-1 the rotation
// is zero and this degenerates to a plain highest-index priority encoder.
module prio_rr_search
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_safe(N)
) (
  input  logic [N-1:0] i_d,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_win,
  output logic         o_any
);

  logic [N-1:0] w_rot;
  int           w_sh;
  int           w_j;
  int           w_idx;

  // Rotate right by ptr+1 (mod N), pick highest set bit, undo the rotation.
  always_comb begin
    w_rot = '0;
    w_j   = 0;
    w_idx = 0;
    w_sh  = (int'(i_ptr) >= N-1) ? 0 : int'(i_ptr) + 1;
    for (int i = 0; i < N; i++) begin
      w_idx    = (i + w_sh >= N) ? (i + w_sh - N) : (i + w_sh);
      w_rot[i] = i_d[w_idx];
    end
    for (int i = 0; i < N; i++) begin
      if (w_rot[i]) w_j = i;
    end
    w_idx = (w_j + w_sh >= N) ? (w_j + w_sh - N) : (w_j + w_sh);
    o_win = W'(w_idx);
    o_any = |i_d;
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin
// priority and a one-entry valid/ready output slot.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = clog2_safe(N),
  parameter int MODE = MODE_FIXED
) (
  input logic          clk,
  input logic          rst,
  prio_encoder_rr_if.slave bus
);

  logic [W-1:0] r_y;
  logic         r_valid;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic [W-1:0] w_ptr;
  logic [W-1:0] w_win;
  logic         w_any;
  logic         w_load;
  logic         w_multi;

  // Fixed mode always searches from the top; the stored pointer is ignored.
  assign w_ptr   = (MODE == MODE_RR) ? r_ptr : W'(N-1);
  assign w_load  = bus.en && (!r_valid || bus.ready);
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi = |(bus.d & (bus.d - 1'b1));

  prio_rr_search #(.N(N), .W(W)) u_search (
    .i_d   (bus.d),
    .i_ptr (w_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  // Output slot (EMPTY/FULL via valid) plus round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_ptr   <= W'(N-1);
    end else if (w_load) begin
      if (w_any) begin
        r_y     <= w_win;
        r_valid <= 1'b1;
        r_multi <= w_multi;
        // Granted index drops to lowest priority; wrap uses N-1, not 2^W-1.
        if (MODE == MODE_RR)
          r_ptr <= (w_win == '0) ? W'(N-1) : w_win - 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (r_valid && bus.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.y     = r_y;
  assign bus.valid = r_valid;
  assign bus.multi = r_multi;

endmodule
